// File: rtl/bcd_display_defs.sv
// Shared constants for the multiplexed BCD display: segment patterns ({g,f,e,d,c,b,a},
// active-low) and the default scan timing.
package bcd_display_defs;

    typedef logic [6:0] seg_t;

    localparam int DEF_CLK_DIV      = 50000;
    localparam int DEF_BLANK_CYCLES = 1000;

    localparam int NUM_DIGITS = 5;
    localparam int NUM_POS    = 6;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_MINUS = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Display value in (load strobe, sign, five BCD digits) and scanned anode/segment drive out.
interface bcd_display_scan_if;
    import bcd_display_defs::*;

    logic       load;
    logic       negative;
    logic [3:0] bcd_digit0;
    logic [3:0] bcd_digit1;
    logic [3:0] bcd_digit2;
    logic [3:0] bcd_digit3;
    logic [3:0] bcd_digit4;
    logic [5:0] an;
    seg_t       seg;

    modport master (
        output load, negative, bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4,
        input  an, seg
    );

    modport slave (
        input  load, negative, bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4,
        output an, seg
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment encoder; values above 9 render as "E".
module bcd_to_seg7
    import bcd_display_defs::*;
(
    input  logic [3:0] digit,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Six-position multiplexed display driver: shadow-registers a signed 5-digit BCD value and
// scans it with leading-zero blanking and an anti-ghost blank window; an/seg are registered.
module bcd_display_scan
    import bcd_display_defs::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    bcd_display_scan_if.slave  bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]  presc;
    logic [2:0]     idx;
    logic [4:0][3:0] sh_dig;
    logic           sh_neg;

    logic           tick;
    logic           blank_win;
    logic [3:0]     cur_dig;
    seg_t           dig_seg;
    logic [7:0]     show;
    logic [5:0]     next_an;
    seg_t           next_seg;

    assign tick      = (presc == PRESC_LAST);
    assign blank_win = (int'(presc) < BLANK_CYCLES);

    always_comb begin
        cur_dig = 4'd0;
        case (idx)
            3'd0:    cur_dig = sh_dig[0];
            3'd1:    cur_dig = sh_dig[1];
            3'd2:    cur_dig = sh_dig[2];
            3'd3:    cur_dig = sh_dig[3];
            3'd4:    cur_dig = sh_dig[4];
            default: cur_dig = 4'd0;
        endcase
    end

    // show[k] is set when some digit at position k or above is nonzero; ones always shows.
    always_comb begin
        show    = '0;
        show[4] = |sh_dig[4];
        show[3] = show[4] | (|sh_dig[3]);
        show[2] = show[3] | (|sh_dig[2]);
        show[1] = show[2] | (|sh_dig[1]);
        show[0] = 1'b1;
    end

    bcd_to_seg7 u_enc (
        .digit (cur_dig),
        .seg   (dig_seg)
    );

    always_comb begin
        next_an  = 6'b111111;
        next_seg = SEG_BLANK;
        if (!blank_win) begin
            next_an = ~(6'd1 << idx);
            if (idx == 3'd5) begin
                next_seg = sh_neg ? SEG_MINUS : SEG_BLANK;
            end else begin
                next_seg = show[idx] ? dig_seg : SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            idx     <= 3'd0;
            sh_dig  <= '0;
            sh_neg  <= 1'b0;
            bus.an  <= 6'b111111;
            bus.seg <= SEG_BLANK;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (bus.load) begin
                sh_dig <= {bus.bcd_digit4, bus.bcd_digit3, bus.bcd_digit2,
                           bus.bcd_digit1, bus.bcd_digit0};
                sh_neg <= bus.negative;
            end
            bus.an  <= next_an;
            bus.seg <= next_seg;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized and directed checks of bcd_display_scan against a cycle-count based display model.
module tb_bcd_display_scan;

    localparam int CD = 4;
    localparam int BC = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    bcd_display_scan_if bus();

    bcd_display_scan #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk   = 1'b0;

    // Model state: edges since reset release and the captured display value.
    int         n = 0;
    int         m_dig [5];
    bit         m_neg = 1'b0;
    logic [5:0] exp_an  = 6'b111111;
    logic [6:0] exp_seg = 7'b1111111;

    function automatic logic [6:0] pattern(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    task automatic model_out(output logic [5:0] a, output logic [6:0] s);
        int presc, pos, msd;
        presc = n % CD;
        pos   = (n / CD) % 6;
        msd   = 0;
        for (int k = 0; k < 5; k++) if (m_dig[k] != 0) msd = k;
        a = 6'b111111;
        s = 7'b1111111;
        if (presc >= BC) begin
            a = 6'b111111;
            a[pos] = 1'b0;
            if (pos == 5)       s = m_neg ? 7'b0111111 : 7'b1111111;
            else if (pos > msd) s = 7'b1111111;
            else                s = pattern(m_dig[pos]);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0;
            for (int k = 0; k < 5; k++) m_dig[k] = 0;
            m_neg   = 1'b0;
            exp_an  = 6'b111111;
            exp_seg = 7'b1111111;
        end else begin
            model_out(exp_an, exp_seg);
            if (bus.load) begin
                m_dig[0] = int'(bus.bcd_digit0);
                m_dig[1] = int'(bus.bcd_digit1);
                m_dig[2] = int'(bus.bcd_digit2);
                m_dig[3] = int'(bus.bcd_digit3);
                m_dig[4] = int'(bus.bcd_digit4);
                m_neg    = bus.negative;
            end
            n++;
        end
    end

    task automatic check(input string nm, input logic [6:0] got, input logic [6:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("model_an", {1'b0, bus.an}, {1'b0, exp_an});
            check("model_seg", bus.seg, exp_seg);
        end
    end

    task automatic set_val(input int d0, d1, d2, d3, d4, input bit neg);
        bus.bcd_digit0 = 4'(d0);
        bus.bcd_digit1 = 4'(d1);
        bus.bcd_digit2 = 4'(d2);
        bus.bcd_digit3 = 4'(d3);
        bus.bcd_digit4 = 4'(d4);
        bus.negative   = neg;
    endtask

    task automatic load_val(input int d0, d1, d2, d3, d4, input bit neg);
        set_val(d0, d1, d2, d3, d4, neg);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_pos(input int k, input logic [6:0] seg_want, input string nm);
        logic [5:0] want_an;
        int c;
        want_an = 6'b111111;
        want_an[k] = 1'b0;
        c = 0;
        @(negedge clk);
        while (exp_an !== want_an && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (c >= 40) begin
            tests++;
            fails++;
            $display("FAIL %s: position %0d not reached, got an %b expected %b", nm, k, bus.an, want_an);
        end else begin
            check(nm, bus.seg, seg_want);
        end
    endtask

    // Literal anode/segment sequence for the first 8 edges after reset release.
    task automatic check_startup(input logic [6:0] seg0, input string nm);
        logic [5:0] an_seq [8];
        logic [6:0] seg1;
        an_seq = '{6'b111111, 6'b111110, 6'b111110, 6'b111110,
                   6'b111111, 6'b111101, 6'b111101, 6'b111101};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bus.load = 1'b0;
            check({nm, "_an"}, {1'b0, bus.an}, {1'b0, an_seq[i]});
            seg1 = (i == 0 || i == 4) ? 7'b1111111 : (i < 4 ? seg0 : bus.seg);
            if (i < 5) check({nm, "_seg"}, bus.seg, seg1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 1'b0;
        set_val(0, 0, 0, 0, 0, 1'b0);
        reset_n = 1'b0;
        chk = 1'b1;

        // Reset holds outputs blank even with load toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_an", {1'b0, bus.an}, 7'b0111111);
            check("rst_seg", bus.seg, 7'b1111111);
            bus.load = ~bus.load;
            bus.bcd_digit0 = 4'($urandom_range(1, 9));
        end

        // Scan order with 1..5 and sign.
        set_val(1, 2, 3, 4, 5, 1'b1);
        bus.load = 1'b1;
        reset_n = 1'b1;
        check_startup(7'b1111001, "scan");
        wait_pos(2, 7'b0110000, "scan_pos2");
        wait_pos(3, 7'b0011001, "scan_pos3");
        wait_pos(4, 7'b0010010, "scan_pos4");
        wait_pos(5, 7'b0111111, "scan_pos5");

        // Leading-zero blanking.
        load_val(0, 7, 0, 0, 0, 1'b0);
        wait_pos(0, 7'b1000000, "lz_pos0");
        wait_pos(1, 7'b1111000, "lz_pos1");
        wait_pos(2, 7'b1111111, "lz_pos2");
        wait_pos(4, 7'b1111111, "lz_pos4");
        wait_pos(5, 7'b1111111, "lz_pos5");
        load_val(0, 0, 0, 0, 0, 1'b0);
        wait_pos(0, 7'b1000000, "zero_pos0");
        wait_pos(1, 7'b1111111, "zero_pos1");
        wait_pos(4, 7'b1111111, "zero_pos4");

        // Invalid digit renders as E and keeps lower digits visible.
        load_val(0, 0, 12, 0, 0, 1'b0);
        wait_pos(1, 7'b1000000, "inv_pos1");
        wait_pos(2, 7'b0000110, "inv_pos2");
        wait_pos(3, 7'b1111111, "inv_pos3");
        wait_pos(4, 7'b1111111, "inv_pos4");

        // Load coinciding with a tick, then mid-slot.
        for (int c = 0; c < 20 && (n % CD) != CD - 1; c++) @(negedge clk);
        load_val(9, 8, 0, 0, 0, 1'b1);
        for (int c = 0; c < 20 && (n % CD) != 2; c++) @(negedge clk);
        load_val(3, 0, 0, 6, 0, 1'b0);
        repeat (30) @(negedge clk);

        // Randomized loads biased toward zeros and occasional invalid digits.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 5) == 0) begin
                int d [5];
                for (int k = 0; k < 5; k++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    d[k] = (r < 5) ? 0 : ((r < 9) ? $urandom_range(1, 9) : $urandom_range(10, 15));
                end
                set_val(d[0], d[1], d[2], d[3], d[4], 1'($urandom_range(0, 1)));
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;

        // Asynchronous reset between edges while at index 3.
        load_val(1, 2, 3, 4, 5, 1'b1);
        for (int c = 0; c < 40 && !(((n / CD) % 6) == 3 && (n % CD) == 2); c++) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_an", {1'b0, bus.an}, 7'b0111111);
        check("arst_seg", bus.seg, 7'b1111111);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_startup(7'b1000000, "restart");

        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot (legal range >= 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, anti-ghost cycles at the start of each slot (legal range 0 .. CLK_DIV-1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1 bit, capture strobe for the value to display.
REQ-006 SHALL have port negative, input, 1 bit, sign flag from the binary-to-BCD stage.
REQ-007 SHALL have ports bcd_digit0 .. bcd_digit4, input, 4 bits each, BCD digits (digit0 = ones, digit4 = ten-thousands).
REQ-008 SHALL have port an, output, 6 bits, active-low position enables (an[0] = ones, an[5] = sign).
REQ-009 SHALL have port seg, output, 7 bits, active-low segments ordered {g,f,e,d,c,b,a}.

Function
REQ-010 SHALL, on a clk edge with load=1, capture negative and all five digits into shadow registers.
REQ-011 SHALL hold the shadow registers unchanged when load=0.
REQ-012 SHALL count a prescaler from 0 to CLK_DIV-1, then wrap to 0; the wrap cycle is a "tick".
REQ-013 SHALL advance a scan index 0,1,2,3,4,5,0,... on every tick; index 5 wraps to 0.
REQ-014 SHALL register an and seg, so each output reflects the index, prescaler and shadow values of the previous cycle (1-cycle latency).
REQ-015 SHALL drive an = 6'b111111 and seg = 7'b1111111 while prescaler < BLANK_CYCLES.
REQ-016 SHALL otherwise drive an with only bit [index] low.
REQ-017 SHALL encode digits 0-9 in seg with standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-018 SHALL show any digit value above 9 as "E" (7'b0000110); such a digit counts as nonzero for blanking.
REQ-019 SHALL blank (seg = 7'b1111111) any position k in 1..4 whose shadow digits k..4 are all zero; position 0 is never blanked.
REQ-020 SHALL, at position 5, show "-" (7'b0111111) when shadow negative = 1, and blank otherwise.
REQ-021 SHALL apply a load in the same cycle as a tick; neither event suppresses the other.
REQ-022 SHALL, on load, neither restart the scan nor reset the prescaler; new values appear at the next display computation.

Reset
REQ-023 SHALL, while reset_n = 0, force prescaler = 0, index = 0, shadow digits = 0, shadow negative = 0, an = 6'b111111, seg = 7'b1111111, regardless of clk.
REQ-024 SHALL resume counting from prescaler 0, index 0 on the first clk edge after reset_n rises; a reset mid-slot discards that slot.

Structure
REQ-025 SHALL place the segment pattern constants (digits 0-9, E, minus, blank) and the default CLK_DIV/BLANK_CYCLES values in a shared include, bcd_display_defs.
REQ-026 SHALL implement the digit-to-segment mapping as a combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out, E for values above 9).

Verification (CLK_DIV=4, BLANK_CYCLES=1)
REQ-027 SHALL test reset: hold reset_n = 0 for 3 clocks while toggling load -> an = 111111, seg = 1111111 throughout.
REQ-028 SHALL test scan order: load digits 1,2,3,4,5, negative = 1 -> an low bit walks 0..5 every 4 cycles, 1 blank cycle per slot, seg = 1,2,3,4,5,"-".
REQ-029 SHALL test leading-zero blanking: load 0,7,0,0,0, negative = 0 -> pos0 = "0", pos1 = "7", pos2-5 blank; then load all zeros -> only pos0 = "0".
REQ-030 SHALL test an invalid digit: load digit2 = 4'hC, others 0 -> pos2 = "E", pos1 = "0" (not blanked), pos3-4 blank.
REQ-031 SHALL test simultaneous events: assert load on a tick cycle and in mid-slot -> scan timing unchanged, new values shown one cycle later.
REQ-032 SHALL test asynchronous reset mid-slot: pull reset_n low between clock edges at index 3 -> outputs blank immediately; after release, scan restarts at index 0.
